seg7_bcd_mux: RTL

- Downstream display stage for the board's 4-digit common-anode seven-segment display.
- Converts the binary value `num` to four BCD digits with a sequential double-dabble engine, then time-multiplexes the digits onto the anodes.
- Consumes the scrolled value produced by the scroll/button front end and drives the `Anode` and `seg` pins directly.

---
 rtl/seg7_bcd_mux.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/seg7_bcd_mux.sv
// seg7_bcd_mux: binary-to-BCD display driver for a 4-digit common-anode
// seven-segment display.
//
// The binary input `num` is converted to four BCD digits by a sequential
// double-dabble engine (one shift per clock). The resulting digits are
// time-multiplexed onto the anodes by a free-running refresh counter.
//
// Ports:
//   clk    - system clock
//   rst    - synchronous, active-high reset
//   num    - binary value to display (DATA_W bits)
//   Anode  - digit enables, active-low, one-hot-low; bit0 = ones digit
//   seg    - segments {g,f,e,d,c,b,a}, active-low
//   busy   - high while a conversion is in progress
//   ovf    - high while the displayed value exceeds 9999 (dashes shown)
module seg7_bcd_mux #(
    parameter int unsigned DATA_W    = 13,
    parameter int unsigned REFRESH_W = 18,
    parameter bit          BLANK_LZ  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] num,
    output logic [3:0]        Anode,
    output logic [6:0]        seg,
    output logic              busy,
    output logic              ovf
);

    localparam int unsigned BCD_W     = 16;
    localparam int unsigned CNT_W     = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    // Comparison width wide enough to hold 9999 regardless of DATA_W.
    localparam int unsigned CMP_W     = (DATA_W > 14) ? DATA_W : 14;
    localparam int unsigned MAX_SHOWN = 9999;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 pending_q, pending_d;
    logic [DATA_W-1:0]    last_num_q, last_num_d;
    logic [DATA_W-1:0]    bin_q, bin_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [BCD_W-1:0]     bcd_adj;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [BCD_W-1:0]     digits_q, digits_d;
    logic                 busy_d;
    logic                 ovf_d;

    logic [REFRESH_W-1:0] refresh_q;
    logic [1:0]           sel;
    logic [3:0]           digit;
    logic                 lead_zero;
    logic [3:0]           anode_d;
    logic [6:0]           seg_d;

    // Active-low {g..a} pattern for a decimal digit; non-decimal codes blank.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble add-3 step; each nibble is corrected independently.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= 1'b1;
            last_num_q <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            bit_cnt_q  <= '0;
            digits_q   <= '0;
            busy       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            last_num_q <= last_num_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            bit_cnt_q  <= bit_cnt_d;
            digits_q   <= digits_d;
            busy       <= busy_d;
            ovf        <= ovf_d;
        end
    end

    // Conversion FSM next-state and datapath logic.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        last_num_d = last_num_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        bit_cnt_d  = bit_cnt_q;
        digits_d   = digits_q;
        busy_d     = busy;
        ovf_d      = ovf;

        case (state_q)
            IDLE: begin
                // num is only sampled here; the latest value always wins.
                if (pending_q || (num != last_num_q)) begin
                    last_num_d = num;
                    bin_d      = num;
                    bcd_d      = '0;
                    bit_cnt_d  = CNT_W'(DATA_W - 1);
                    pending_d  = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
                bin_d = {bin_q[DATA_W-2:0], 1'b0};
                if (bit_cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                digits_d = bcd_q;
                ovf_d    = (CMP_W'(last_num_q) > CMP_W'(MAX_SHOWN));
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sel = refresh_q[REFRESH_W-1 -: 2];

    // Digit select, leading-zero detection and segment pattern for this sel.
    always_comb begin
        anode_d   = 4'b1110;
        digit     = digits_q[3:0];
        lead_zero = 1'b0;
        seg_d     = SEG_BLANK;

        case (sel)
            2'd0: begin
                anode_d   = 4'b1110;
                digit     = digits_q[3:0];
                lead_zero = 1'b0;
            end
            2'd1: begin
                anode_d   = 4'b1101;
                digit     = digits_q[7:4];
                lead_zero = (digits_q[15:4] == 12'd0);
            end
            2'd2: begin
                anode_d   = 4'b1011;
                digit     = digits_q[11:8];
                lead_zero = (digits_q[15:8] == 8'd0);
            end
            default: begin
                anode_d   = 4'b0111;
                digit     = digits_q[15:12];
                lead_zero = (digits_q[15:12] == 4'd0);
            end
        endcase

        if (ovf) begin
            seg_d = SEG_DASH;
        end else if (BLANK_LZ && lead_zero) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_of(digit);
        end
    end

    // Refresh counter and display outputs; Anode and seg share one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_q <= '0;
            Anode     <= 4'b1111;
            seg       <= SEG_BLANK;
        end else begin
            refresh_q <= refresh_q + REFRESH_W'(1);
            Anode     <= anode_d;
            seg       <= seg_d;
        end
    end

endmodule
